// File: rtl/dp_types_pkg.sv
// Shared datapath types and helpers; here the branch target buffer mode and PC field extraction.
package dp_types_pkg;

    typedef enum logic {
        BTB_ONLY = 1'b0,
        BIMODAL  = 1'b1
    } btb_mode_t;

    // Word-aligned PCs: bits [1:0] never participate in index or tag.
    function automatic logic [31:0] btb_index(input logic [31:0] pc, input int unsigned idx);
        return (pc >> 2) & ((32'd1 << idx) - 32'd1);
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int unsigned idx);
        return pc >> (idx + 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Combinational up/down counter step that saturates at zero and at all-ones.
module sat_counter #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next
);

    always_comb begin
        next = cur;
        if (inc && !dec && (cur != '1)) begin
            next = cur + 1'b1;
        end else if (dec && !inc && (cur != '0)) begin
            next = cur - 1'b1;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with per-entry direction counters, looked up by IF and trained from EX/MEM.
module branch_target_buffer
    import dp_types_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned MODE     = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] upd_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned IDX   = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX - 2;
    localparam btb_mode_t   Mode  = btb_mode_t'(MODE[0]);
    localparam logic [CTR_BITS-1:0] CtrWeakTaken = CTR_BITS'(1 << (CTR_BITS - 1));

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [31:0]         target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;

    entry_t table_q [ENTRIES];

    logic [IDX-1:0]      l_idx, u_idx;
    logic [TAG_W-1:0]    l_tag, u_tag;
    logic                l_hit, u_hit;
    entry_t              l_entry, u_entry, entry_d;
    logic                entry_we;
    logic [CTR_BITS-1:0] ctr_next;
    logic [31:0]         upd_count_q, upd_count_d;
    logic [31:0]         mispred_count_q, mispred_count_d;

    assign l_idx   = IDX'(btb_index(lookup_pc, IDX));
    assign l_tag   = TAG_W'(btb_tag(lookup_pc, IDX));
    assign u_idx   = IDX'(btb_index(upd_pc, IDX));
    assign u_tag   = TAG_W'(btb_tag(upd_pc, IDX));
    assign l_entry = table_q[l_idx];
    assign u_entry = table_q[u_idx];
    assign l_hit   = l_entry.valid && (l_entry.tag == l_tag);
    assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);

    // Lookup sees only registered state, so a same-cycle update is visible next cycle.
    assign predict_taken  = l_hit && ((Mode == BTB_ONLY) || l_entry.ctr[CTR_BITS-1]);
    assign predict_target = predict_taken ? l_entry.target : 32'd0;

    assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                      (upd_taken && (upd_pred_target != upd_target)));

    sat_counter #(.W(CTR_BITS)) u_dir_ctr (
        .cur  (u_entry.ctr),
        .inc  (upd_taken),
        .dec  (!upd_taken),
        .next (ctr_next)
    );

    sat_counter #(.W(32)) u_upd_cnt (
        .cur  (upd_count_q),
        .inc  (upd_valid),
        .dec  (1'b0),
        .next (upd_count_d)
    );

    sat_counter #(.W(32)) u_mispred_cnt (
        .cur  (mispred_count_q),
        .inc  (mispredict),
        .dec  (1'b0),
        .next (mispred_count_d)
    );

    always_comb begin
        entry_d  = u_entry;
        entry_we = 1'b0;
        if (upd_valid) begin
            if (u_hit) begin
                entry_we    = 1'b1;
                entry_d.ctr = ctr_next;
                if (upd_taken) begin
                    entry_d.target = upd_target;
                end
            end else if (upd_taken) begin
                // Miss on a taken branch evicts whatever occupied this slot.
                entry_we       = 1'b1;
                entry_d.valid  = 1'b1;
                entry_d.tag    = u_tag;
                entry_d.target = upd_target;
                entry_d.ctr    = CtrWeakTaken;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= '0;
            end
            upd_count_q     <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            if (entry_we) begin
                table_q[u_idx] <= entry_d;
            end
            upd_count_q     <= upd_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign upd_count     = upd_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed vector bench for branch_target_buffer: bimodal instance plus a BTB-only twin on shared stimulus.
module tb_branch_target_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        predict_taken, predict_taken0;
    logic [31:0] predict_target, predict_target0;
    logic        mispredict, mispredict0;
    logic [31:0] upd_count, upd_count0;
    logic [31:0] mispred_count, mispred_count0;

    always #5 CLK = ~CLK;

    branch_target_buffer #(.ENTRIES(16), .CTR_BITS(2), .MODE(1)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .lookup_pc       (lookup_pc),
        .predict_taken   (predict_taken),
        .predict_target  (predict_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .upd_count       (upd_count),
        .mispred_count   (mispred_count)
    );

    branch_target_buffer #(.ENTRIES(16), .CTR_BITS(2), .MODE(0)) dut0 (
        .CLK             (CLK),
        .RST             (RST),
        .lookup_pc       (lookup_pc),
        .predict_taken   (predict_taken0),
        .predict_target  (predict_target0),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict0),
        .upd_count       (upd_count0),
        .mispred_count   (mispred_count0)
    );

    typedef struct {
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        ept;
        logic [31:0] etgt;
        logic        emis;
        logic [31:0] euc;
        logic [31:0] emc;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic upt,
                                input logic [31:0] uptgt, input logic ept,
                                input logic [31:0] etgt, input logic emis,
                                input logic [31:0] euc, input logic [31:0] emc);
        vec_t v;
        v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt;
        v.uptgt = uptgt; v.ept = ept; v.etgt = etgt; v.emis = emis; v.euc = euc; v.emc = emc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_upd(input logic uv, input logic [31:0] upc, input logic ut,
                             input logic [31:0] utgt, input logic upt, input logic [31:0] uptgt);
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
    endtask

    initial begin
        RST       = 1'b1;
        lookup_pc = 32'h40;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Expected values are the state before the edge that follows each vector.
        //            lpc     uv  upc     ut  utgt    upt uptgt   ept etgt    mis uc  mc
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0,  0));
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 0,  0));
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 1,  1));
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   1, 32'h100, 1, 32'h100, 1, 1,  1));
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 2,  2));
        vecs.push_back(mk(32'h40, 1, 32'h40, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 3,  2));
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 4,  2));
        vecs.push_back(mk(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h0,   0, 32'h0,   1, 5,  3));
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 6,  4));
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 6,  4));
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h0,   0, 32'h0,   1, 6,  4));
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 7,  5));
        vecs.push_back(mk(32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 7,  5));
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h200, 1, 32'h200, 1, 7,  5));
        vecs.push_back(mk(32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h300, 1, 32'h300, 0, 8,  6));
        vecs.push_back(mk(32'h80, 1, 32'h80, 0, 32'h0,   1, 32'h300, 1, 32'h300, 1, 9,  6));
        vecs.push_back(mk(32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 10, 7));
        vecs.push_back(mk(32'h44, 1, 32'h44, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 10, 7));
        vecs.push_back(mk(32'h44, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 11, 7));
        vecs.push_back(mk(32'h4B, 1, 32'h48, 1, 32'h480, 0, 32'h0,   0, 32'h0,   1, 11, 7));
        vecs.push_back(mk(32'h4B, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h480, 0, 12, 8));

        repeat (2) @(posedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST       = 1'b0;
            lookup_pc = vecs[i].lpc;
            drive_upd(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].upt,
                      vecs[i].uptgt);
            #1;
            check($sformatf("v%0d predict_taken", i), 32'(predict_taken), 32'(vecs[i].ept));
            check($sformatf("v%0d predict_target", i), predict_target, vecs[i].etgt);
            check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].emis));
            check($sformatf("v%0d upd_count", i), upd_count, vecs[i].euc);
            check($sformatf("v%0d mispred_count", i), mispred_count, vecs[i].emc);
        end

        // Reset together with an update: the update must be dropped.
        @(negedge CLK);
        RST = 1'b1;
        drive_upd(1'b1, 32'h4C, 1'b1, 32'h999, 1'b0, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup_pc = 32'h80;
        #1;
        check("rst hit 0x80", 32'(predict_taken), 32'd0);
        check("rst hit 0x80 mode0", 32'(predict_taken0), 32'd0);
        check("rst upd_count", upd_count, 32'd0);
        check("rst mispred_count", mispred_count, 32'd0);
        lookup_pc = 32'h4B;
        #1;
        check("rst hit 0x48", 32'(predict_taken), 32'd0);
        check("rst hit 0x48 mode0", 32'(predict_taken0), 32'd0);
        lookup_pc = 32'h4C;
        #1;
        check("rst dropped upd 0x4C", 32'(predict_taken), 32'd0);
        check("rst dropped upd 0x4C mode0", 32'(predict_taken0), 32'd0);

        // Allocate, then decay the counter to 0: only the BTB-only twin still predicts taken.
        @(negedge CLK);
        drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        @(negedge CLK);
        drive_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        drive_upd(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge CLK);
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup_pc = 32'h40;
        #1;
        check("ctr0 bimodal predict_taken", 32'(predict_taken), 32'd0);
        check("ctr0 bimodal predict_target", predict_target, 32'd0);
        check("ctr0 mode0 predict_taken", 32'(predict_taken0), 32'd1);
        check("ctr0 mode0 predict_target", predict_target0, 32'h100);
        check("post upd_count", upd_count, 32'd3);
        check("post mispred_count", mispred_count, 32'd1);
        check("post mode0 upd_count", upd_count0, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
